// File: rtl/maze_port_arbiter.sv
// Round-robin arbiter sharing the single maze memory port between the solver
// (requester 0) and the host/display scan engine (requester 1).
module maze_port_arbiter #(
    parameter int maze_width = 6,
    parameter int BURST_LEN  = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,

    input  logic                  req0_valid,
    output logic                  req0_ready,
    input  logic [maze_width-1:0] req0_row,
    input  logic [maze_width-1:0] req0_col,
    input  logic                  req0_oe,
    input  logic                  req0_we,

    input  logic                  req1_valid,
    output logic                  req1_ready,
    input  logic [maze_width-1:0] req1_row,
    input  logic [maze_width-1:0] req1_col,
    input  logic                  req1_oe,
    input  logic                  req1_we,

    output logic                  rsp0_valid,
    output logic                  rsp1_valid,
    output logic                  rsp_data,

    output logic [maze_width-1:0] row,
    output logic [maze_width-1:0] col,
    output logic                  maze_oe,
    output logic                  maze_we,
    input  logic                  maze_in,

    output logic                  err_both
);

    localparam logic [3:0] BURST_MAX = 4'(BURST_LEN);

    logic                  last_grant;
    logic [3:0]            burst_cnt;
    logic [3:0]            burst_cnt_nxt;

    logic                  grant_any;
    logic                  grant_id;
    logic [maze_width-1:0] sel_row;
    logic [maze_width-1:0] sel_col;
    logic                  sel_oe;
    logic                  sel_we;

    // In-flight read tracking: stage 1 lines up with the issued strobes,
    // stage 2 with maze_in.
    logic                  s1_read;
    logic                  s1_id;
    logic                  s2_read;
    logic                  s2_id;

    // A zero burst count means the previous cycle had no grant, so the burst
    // hold only applies while a run is actually in progress.
    always_comb begin
        grant_any = req0_valid | req1_valid;
        grant_id  = 1'b0;
        if (req0_valid && req1_valid) begin
            if ((burst_cnt != '0) && (burst_cnt < BURST_MAX))
                grant_id = last_grant;
            else
                grant_id = ~last_grant;
        end else begin
            grant_id = req1_valid;
        end
    end

    assign req0_ready = req0_valid & ~grant_id;
    assign req1_ready = req1_valid &  grant_id;

    always_comb begin
        sel_row = req0_row;
        sel_col = req0_col;
        sel_oe  = req0_oe;
        sel_we  = req0_we;
        if (grant_id) begin
            sel_row = req1_row;
            sel_col = req1_col;
            sel_oe  = req1_oe;
            sel_we  = req1_we;
        end
    end

    always_comb begin
        burst_cnt_nxt = '0;
        if (grant_any) begin
            if (grant_id == last_grant)
                burst_cnt_nxt = (burst_cnt < BURST_MAX) ? burst_cnt + 4'd1 : burst_cnt;
            else
                burst_cnt_nxt = 4'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_grant <= 1'b1;
            burst_cnt  <= '0;
        end else begin
            burst_cnt <= burst_cnt_nxt;
            if (grant_any)
                last_grant <= grant_id;
        end
    end

    // Write wins over read when both strobes are set; no read is tracked then.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            row      <= '0;
            col      <= '0;
            maze_oe  <= 1'b0;
            maze_we  <= 1'b0;
            err_both <= 1'b0;
        end else begin
            maze_oe <= grant_any & sel_oe & ~sel_we;
            maze_we <= grant_any & sel_we;
            if (grant_any) begin
                row <= sel_row;
                col <= sel_col;
            end
            if (grant_any && sel_oe && sel_we)
                err_both <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_read <= 1'b0;
            s1_id   <= 1'b0;
            s2_read <= 1'b0;
            s2_id   <= 1'b0;
        end else begin
            s1_read <= grant_any & sel_oe & ~sel_we;
            s1_id   <= grant_id;
            s2_read <= s1_read;
            s2_id   <= s1_id;
        end
    end

    assign rsp0_valid = s2_read & ~s2_id;
    assign rsp1_valid = s2_read &  s2_id;
    assign rsp_data   = maze_in;

endmodule

// File: tb/tb_maze_port_arbiter.sv
// Directed bench for maze_port_arbiter with a read-response scoreboard.
module tb_maze_port_arbiter;

    localparam int MW = 6;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          req0_valid, req0_ready, req0_oe, req0_we;
    logic [MW-1:0] req0_row, req0_col;
    logic          req1_valid, req1_ready, req1_oe, req1_we;
    logic [MW-1:0] req1_row, req1_col;
    logic          rsp0_valid, rsp1_valid, rsp_data;
    logic [MW-1:0] row, col;
    logic          maze_oe, maze_we;
    logic          maze_in = 1'b0;
    logic          err_both;

    typedef struct {
        int cyc;
        bit id;
        bit data;
    } exp_t;

    exp_t sb[$];
    exp_t e;
    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;
    bit   mem [64][64];

    maze_port_arbiter #(.maze_width(MW), .BURST_LEN(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_ready(req0_ready),
        .req0_row(req0_row), .req0_col(req0_col), .req0_oe(req0_oe), .req0_we(req0_we),
        .req1_valid(req1_valid), .req1_ready(req1_ready),
        .req1_row(req1_row), .req1_col(req1_col), .req1_oe(req1_oe), .req1_we(req1_we),
        .rsp0_valid(rsp0_valid), .rsp1_valid(rsp1_valid), .rsp_data(rsp_data),
        .row(row), .col(col), .maze_oe(maze_oe), .maze_we(maze_we),
        .maze_in(maze_in), .err_both(err_both)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Memory model: read data appears the cycle after the strobe is presented.
    always @(posedge clk) begin
        if (maze_we) mem[row][col] <= 1'b1;
        maze_in <= maze_oe ? mem[row][col] : 1'b0;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rsp0_valid || rsp1_valid) begin
            if (sb.size() == 0) begin
                check("rsp_unexpected", 32'({rsp1_valid, rsp0_valid}), 32'(0));
            end else begin
                e = sb.pop_front();
                check("rsp_cycle", 32'(cyc), 32'(e.cyc));
                check("rsp_id", 32'({rsp1_valid, rsp0_valid}), e.id ? 32'(2) : 32'(1));
                check("rsp_data", 32'(rsp_data), 32'(e.data));
            end
        end
    end

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        req0_valid = 0; req0_oe = 0; req0_we = 0; req0_row = '0; req0_col = '0;
        req1_valid = 0; req1_oe = 0; req1_we = 0; req1_row = '0; req1_col = '0;
    endtask

    task automatic push(input bit id, input bit data);
        sb.push_back('{cyc + 2, id, data});
    endtask

    initial begin
        rst_n = 1'b0;
        idle();
        mem[5][7] = 1'b1;
        mem[1][1] = 1'b0;
        mem[2][2] = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_row", 32'(row), 32'(0));
        check("reset_col", 32'(col), 32'(0));
        check("reset_oe", 32'(maze_oe), 32'(0));
        check("reset_we", 32'(maze_we), 32'(0));
        check("reset_rsp", 32'({rsp1_valid, rsp0_valid}), 32'(0));
        check("reset_err", 32'(err_both), 32'(0));
        rst_n = 1'b1;
        next_cycle();

        // req0 read at (5,7)
        req0_valid = 1; req0_oe = 1; req0_row = 6'd5; req0_col = 6'd7;
        @(negedge clk);
        check("rd_ready0", 32'(req0_ready), 32'(1));
        check("rd_ready1", 32'(req1_ready), 32'(0));
        push(1'b0, 1'b1);
        next_cycle();
        idle();
        @(negedge clk);
        check("rd_row", 32'(row), 32'(5));
        check("rd_col", 32'(col), 32'(7));
        check("rd_oe", 32'(maze_oe), 32'(1));
        check("rd_we", 32'(maze_we), 32'(0));
        repeat (3) next_cycle();

        // alternating reads: req0 (1,1) then req1 (2,2)
        req0_valid = 1; req0_oe = 1; req0_row = 6'd1; req0_col = 6'd1;
        @(negedge clk);
        check("alt_ready0", 32'(req0_ready), 32'(1));
        push(1'b0, 1'b0);
        next_cycle();
        idle();
        req1_valid = 1; req1_oe = 1; req1_row = 6'd2; req1_col = 6'd2;
        @(negedge clk);
        check("alt_ready1", 32'(req1_ready), 32'(1));
        push(1'b1, 1'b1);
        next_cycle();
        idle();
        repeat (3) next_cycle();

        // both valid continuously: bursts of four
        req0_valid = 1; req1_valid = 1;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            check($sformatf("burst_ready0_%0d", k), 32'(req0_ready), ((k / 4) % 2 == 0) ? 32'(1) : 32'(0));
            check($sformatf("burst_ready1_%0d", k), 32'(req1_ready), ((k / 4) % 2 == 1) ? 32'(1) : 32'(0));
            if (k > 0) check("burst_no_strobe", 32'({maze_oe, maze_we}), 32'(0));
            next_cycle();
        end
        idle();
        repeat (2) next_cycle();

        // req1 write at (0,63)
        req1_valid = 1; req1_we = 1; req1_row = 6'd0; req1_col = 6'd63;
        @(negedge clk);
        check("wr_ready1", 32'(req1_ready), 32'(1));
        next_cycle();
        idle();
        @(negedge clk);
        check("wr_we", 32'(maze_we), 32'(1));
        check("wr_oe", 32'(maze_oe), 32'(0));
        check("wr_row", 32'(row), 32'(0));
        check("wr_col", 32'(col), 32'(63));
        next_cycle();
        @(negedge clk);
        check("idle_we", 32'(maze_we), 32'(0));
        check("idle_hold_col", 32'(col), 32'(63));
        repeat (2) next_cycle();

        // req0 with both strobes at (3,3)
        req0_valid = 1; req0_oe = 1; req0_we = 1; req0_row = 6'd3; req0_col = 6'd3;
        @(negedge clk);
        check("both_ready0", 32'(req0_ready), 32'(1));
        check("both_err_pre", 32'(err_both), 32'(0));
        next_cycle();
        idle();
        @(negedge clk);
        check("both_we", 32'(maze_we), 32'(1));
        check("both_oe", 32'(maze_oe), 32'(0));
        check("both_err", 32'(err_both), 32'(1));
        next_cycle();
        req1_valid = 1; req1_oe = 1; req1_row = 6'd5; req1_col = 6'd7;
        @(negedge clk);
        push(1'b1, 1'b1);
        next_cycle();
        idle();
        repeat (3) next_cycle();
        @(negedge clk);
        check("err_sticky", 32'(err_both), 32'(1));
        next_cycle();

        // read accepted, then reset pulsed in the issue cycle
        req0_valid = 1; req0_oe = 1; req0_row = 6'd9; req0_col = 6'd9;
        @(negedge clk);
        check("rst_rd_ready0", 32'(req0_ready), 32'(1));
        next_cycle();
        idle();
        @(negedge clk);
        check("rst_rd_oe", 32'(maze_oe), 32'(1));
        #1;
        rst_n = 1'b0;
        #1;
        check("rst_async_oe", 32'(maze_oe), 32'(0));
        check("rst_err_clear", 32'(err_both), 32'(0));
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        next_cycle();
        req0_valid = 1; req1_valid = 1;
        @(negedge clk);
        check("post_rst_ready0", 32'(req0_ready), 32'(1));
        check("post_rst_ready1", 32'(req1_ready), 32'(0));
        next_cycle();
        idle();
        repeat (4) next_cycle();

        check("sb_drained", 32'(sb.size()), 32'(0));
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
